tensor_velocity_solve: RTL and testbench
========================================

# tensor_velocity_solve

Per-pixel velocity solver that turns a packed structure tensor into the fixed-point flow vector (vx, vy) by solving the 2×2 least-squares system with Cramer's rule. Sits directly upstream of the k/error-variance stage and forwards the tensor word with its result, so both reach that stage together. Division is a shared-control sequential restoring divider, so the block is multi-cycle with a valid/ready handshake on both sides.

## Interface
Parameters:
- TENSOR_WIDTH, 14: width of each signed tensor element and of vx/vy.
- FRAC_BITS, TENSOR_WIDTH/2: fractional bits of vx/vy.
- DET_MIN, 0: the solve is degenerate when |det| <= DET_MIN.

Ports:
- clk  in  1  clock. Single clock domain; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  tensor word valid.
- in_ready  out  1  block can accept.
- tensors  in  TENSOR_WIDTH*6  packed {xx,xy,xt,yy,yt,tt}, xx in the MSB slice, each element signed.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- tensors_out  out  TENSOR_WIDTH*6  captured input word, unchanged.
- vx, vy  out  TENSOR_WIDTH each  signed velocity with FRAC_BITS fractional bits.
- degenerate  out  1  det failed the DET_MIN test; vx = vy = 0.

## Operation
- Arithmetic:
  - det = xx·yy − xy².
  - num_x = xy·yt − yy·xt.
  - num_y = xy·xt − xx·yt.
- Widths:
  - Products are 2·TW signed.
  - det and num are 2·TW+1 signed.
  - NUM_W = 2·TW+1+FRAC_BITS.
- Quotient:
  - Divide |num| << FRAC_BITS by |det|, unsigned restoring, NUM_W iterations.
  - Sign = sign(num) XOR sign(det). Result truncates toward zero.
  - Saturate to [−2^(TW−1), 2^(TW−1)−1].
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture tensors and go to MUL.
  - MUL: register the six products; go to CMB.
  - CMB: form det, num_x, num_y and register signs and magnitudes. If degenerate, go to DONE with vx=vy=0 and degenerate=1. Otherwise load both dividers and go to DIV.
  - DIV: one quotient bit per cycle per divider, with a shared iteration counter. After NUM_W iterations, register the saturated, signed results and go to DONE.
  - DONE: out_valid=1. Outputs hold stable until out_valid && out_ready, then return to IDLE.
- in_ready=0 in every state except IDLE. There is no input acceptance in the same cycle as output release.
- Reset values: state IDLE, out_valid 0, vx 0, vy 0, degenerate 0, tensors_out 0, in_ready 1 after reset release.
- Reset asserted mid-operation aborts immediately. The in-flight word is dropped and never emitted.

## Timing
- Accept edge E0 is the first rising edge with in_valid && in_ready.
- Non-degenerate: out_valid is high after edge E0+2+NUM_W (38 edges for the defaults).
- Degenerate: out_valid is high after edge E0+2.
- Minimum initiation interval: latency + 1 handshake cycle.
- With out_ready held high in DONE, out_valid lasts exactly one cycle.
- With out_ready low, all outputs are frozen for any number of cycles.

## Structure
- Package tensor_flow_pkg holds:
  - TENSOR_WIDTH default and FRAC_BITS default.
  - Tensor slice-offset constants (XX_OFF … TT_OFF).
  - A tensor_t struct for unpacking.
  - The state enum {IDLE, MUL, CMB, DIV, DONE}.
- Sub-module seq_udiv:
  - Parameterised by NUM_W and DEN_W.
  - Ports: load, step, numerator, denominator, quotient.
  - Instantiated twice. The parent FSM owns the counter and sequencing.

## Test plan
Defaults apply throughout (TW=14, FRAC=7).

- Basic solve:
  - Stimulus: xx=100, yy=100, xy=0, xt=−50, yt=25, out_ready=1.
  - Response: vx=64, vy=−32, degenerate=0. out_valid is high after edge E0+38. tensors_out equals the input.
- Truncation toward zero:
  - Stimulus: xx=yy=3, xy=0, xt=−1, yt=0 → vx=42. Then xt=+1 → vx=−42. vy=0 in both cases.
- Degenerate:
  - Stimulus: xx=yy=xy=10 (det=0).
  - Response: vx=vy=0, degenerate=1, out_valid after edge E0+2.
- Saturation:
  - Stimulus: xx=yy=1, xy=0, xt=−8000, yt=0 → vx=8191, vy=0. Then xt=+8000 → vx=−8192.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while offering a second word.
  - Response: outputs stable and in_ready=0 throughout. The second word is accepted only after the handshake and produces the correct result.
- Reset mid-DIV:
  - Stimulus: drop rst_n during iteration 20.
  - Response: all outputs reset immediately and out_valid stays 0. The next word after release computes correctly.

Source files
------------

// File: rtl/tensor_flow_pkg.sv
// Shared types and constants for the structure-tensor velocity solver.
// Tensor element slots are counted in elements from the LSB of the packed word.
package tensor_flow_pkg;

  localparam int TENSOR_WIDTH_DEF = 14;
  localparam int FRAC_BITS_DEF    = TENSOR_WIDTH_DEF / 2;

  localparam int XX_OFF = 5;
  localparam int XY_OFF = 4;
  localparam int XT_OFF = 3;
  localparam int YY_OFF = 2;
  localparam int YT_OFF = 1;
  localparam int TT_OFF = 0;

  typedef struct packed {
    logic signed [TENSOR_WIDTH_DEF-1:0] xx;
    logic signed [TENSOR_WIDTH_DEF-1:0] xy;
    logic signed [TENSOR_WIDTH_DEF-1:0] xt;
    logic signed [TENSOR_WIDTH_DEF-1:0] yy;
    logic signed [TENSOR_WIDTH_DEF-1:0] yt;
    logic signed [TENSOR_WIDTH_DEF-1:0] tt;
  } tensor_t;

  typedef enum logic [2:0] {IDLE, MUL, CMB, DIV, DONE} state_t;

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider, one quotient bit per step; sequencing is owned by the parent.
// o_quotient already includes the bit retired in a stepping cycle, so the parent can capture on the last step.
module seq_udiv #(
  parameter int NUM_W = 36,
  parameter int DEN_W = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [NUM_W-1:0] i_numerator,
  input  logic [DEN_W-1:0] i_denominator,
  output logic [NUM_W-1:0] o_quotient
);
  logic [NUM_W-1:0] r_q;
  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [DEN_W:0]   w_rem_sh;
  logic [DEN_W-1:0] w_rem_next;
  logic [NUM_W-1:0] w_q_next;

  always_comb begin
    w_rem_sh = {r_rem, r_q[NUM_W-1]};
    if (w_rem_sh >= {1'b0, r_den}) begin
      w_rem_next = w_rem_sh[DEN_W-1:0] - r_den;
      w_q_next   = {r_q[NUM_W-2:0], 1'b1};
    end else begin
      w_rem_next = w_rem_sh[DEN_W-1:0];
      w_q_next   = {r_q[NUM_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_rem <= '0;
      r_den <= '0;
    end else if (i_load) begin
      r_q   <= i_numerator;
      r_rem <= '0;
      r_den <= i_denominator;
    end else if (i_step) begin
      r_q   <= w_q_next;
      r_rem <= w_rem_next;
    end
  end

  assign o_quotient = i_step ? w_q_next : r_q;

endmodule

// File: rtl/tensor_velocity_solve.sv
// Cramer's-rule flow solver: tensor word in, saturated fixed-point (vx, vy) out with the word forwarded.
// States: IDLE accept | MUL products | CMB det/num + degenerate test | DIV quotient bits | DONE hold result
module tensor_velocity_solve
  import tensor_flow_pkg::*;
#(
  parameter int TENSOR_WIDTH = TENSOR_WIDTH_DEF,
  parameter int FRAC_BITS    = TENSOR_WIDTH / 2,
  parameter int DET_MIN      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [TENSOR_WIDTH*6-1:0] i_tensors,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [TENSOR_WIDTH*6-1:0] o_tensors_out,
  output logic [TENSOR_WIDTH-1:0]   o_vx,
  output logic [TENSOR_WIDTH-1:0]   o_vy,
  output logic                      o_degenerate
);
  localparam int TW    = TENSOR_WIDTH;
  localparam int P_W   = 2 * TW;
  localparam int D_W   = 2 * TW + 1;
  localparam int NUM_W = D_W + FRAC_BITS;
  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam logic [D_W-1:0]   DET_MIN_V = D_W'(DET_MIN);
  localparam logic [NUM_W-1:0] POS_LIM   = NUM_W'((2 ** (TW - 1)) - 1);
  localparam logic [NUM_W-1:0] NEG_LIM   = NUM_W'(2 ** (TW - 1));

  function automatic logic signed [P_W-1:0] elem(input logic [TW*6-1:0] word, input int idx);
    logic [TW-1:0] e;
    e = word[idx*TW +: TW];
    return {{TW{e[TW-1]}}, e};
  endfunction

  function automatic logic signed [D_W-1:0] diff(input logic signed [P_W-1:0] a,
                                                 input logic signed [P_W-1:0] b);
    return {a[P_W-1], a} - {b[P_W-1], b};
  endfunction

  function automatic logic [D_W-1:0] mag(input logic signed [D_W-1:0] v);
    return v[D_W-1] ? -v : v;
  endfunction

  function automatic logic [TW-1:0] sat(input logic [NUM_W-1:0] q, input logic neg);
    logic [TW-1:0] r;
    if (neg) r = (q > NEG_LIM) ? NEG_LIM[TW-1:0] : -q[TW-1:0];
    else     r = (q > POS_LIM) ? POS_LIM[TW-1:0] : q[TW-1:0];
    return r;
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [TW*6-1:0]         r_tensors;
  logic signed [P_W-1:0]   w_xx, w_xy, w_xt, w_yy, w_yt;
  logic signed [P_W-1:0]   r_p_xxyy, r_p_xyxy, r_p_xyyt, r_p_yyxt, r_p_xyxt, r_p_xxyt;
  logic signed [D_W-1:0]   w_det, w_num_x, w_num_y;
  logic [D_W-1:0]          w_det_mag;
  logic                    w_degen, w_load, w_step;
  logic                    r_neg_x, r_neg_y;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_W-1:0]        w_q_x, w_q_y;
  logic [TW-1:0]           r_vx, r_vy;
  logic                    r_degen;

  assign w_xx = elem(r_tensors, XX_OFF);
  assign w_xy = elem(r_tensors, XY_OFF);
  assign w_xt = elem(r_tensors, XT_OFF);
  assign w_yy = elem(r_tensors, YY_OFF);
  assign w_yt = elem(r_tensors, YT_OFF);

  assign w_det     = diff(r_p_xxyy, r_p_xyxy);
  assign w_num_x   = diff(r_p_xyyt, r_p_yyxt);
  assign w_num_y   = diff(r_p_xyxt, r_p_xxyt);
  assign w_det_mag = mag(w_det);
  assign w_degen   = (w_det_mag <= DET_MIN_V);

  seq_udiv #(.NUM_W(NUM_W), .DEN_W(D_W)) u_div_x (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_numerator   ({mag(w_num_x), {FRAC_BITS{1'b0}}}),
    .i_denominator (w_det_mag),
    .o_quotient    (w_q_x)
  );

  seq_udiv #(.NUM_W(NUM_W), .DEN_W(D_W)) u_div_y (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_numerator   ({mag(w_num_y), {FRAC_BITS{1'b0}}}),
    .i_denominator (w_det_mag),
    .o_quotient    (w_q_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: if (i_in_valid) w_state_nxt = MUL;
      MUL:  w_state_nxt = CMB;
      CMB: begin
        if (w_degen) begin
          w_state_nxt = DONE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = DIV;
        end
      end
      DIV: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      end
      DONE:    if (i_out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tensors <= '0;
      r_p_xxyy  <= '0;
      r_p_xyxy  <= '0;
      r_p_xyyt  <= '0;
      r_p_yyxt  <= '0;
      r_p_xyxt  <= '0;
      r_p_xxyt  <= '0;
      r_neg_x   <= 1'b0;
      r_neg_y   <= 1'b0;
      r_cnt     <= '0;
      r_vx      <= '0;
      r_vy      <= '0;
      r_degen   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_in_valid) r_tensors <= i_tensors;
        MUL: begin
          r_p_xxyy <= w_xx * w_yy;
          r_p_xyxy <= w_xy * w_xy;
          r_p_xyyt <= w_xy * w_yt;
          r_p_yyxt <= w_yy * w_xt;
          r_p_xyxt <= w_xy * w_xt;
          r_p_xxyt <= w_xx * w_yt;
        end
        CMB: begin
          r_neg_x <= w_num_x[D_W-1] ^ w_det[D_W-1];
          r_neg_y <= w_num_y[D_W-1] ^ w_det[D_W-1];
          r_cnt   <= CNT_W'(NUM_W);
          r_degen <= w_degen;
          if (w_degen) begin
            r_vx <= '0;
            r_vy <= '0;
          end
        end
        DIV: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // last step: quotient port already carries the final bit
          if (r_cnt == CNT_W'(1)) begin
            r_vx <= sat(w_q_x, r_neg_x);
            r_vy <= sat(w_q_y, r_neg_y);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready    = (r_state == IDLE);
  assign o_out_valid   = (r_state == DONE);
  assign o_tensors_out = r_tensors;
  assign o_vx          = r_vx;
  assign o_vy          = r_vy;
  assign o_degenerate  = r_degen;

endmodule

// File: tb/tb_tensor_velocity_solve.sv
// Randomised and directed bench for tensor_velocity_solve against a plain-arithmetic reference model.
module tb_tensor_velocity_solve;
  import tensor_flow_pkg::*;

  localparam int TW        = TENSOR_WIDTH_DEF;
  localparam int FRAC      = FRAC_BITS_DEF;
  localparam int LAT_SOLVE = 2 + (2 * TW + 1 + FRAC);
  localparam int LAT_DEGEN = 2;

  logic            clk;
  logic            rst_n;
  logic            i_in_valid;
  logic            o_in_ready;
  logic [TW*6-1:0] i_tensors;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [TW*6-1:0] o_tensors_out;
  logic [TW-1:0]   o_vx;
  logic [TW-1:0]   o_vy;
  logic            o_degenerate;

  int n_cmp = 0;
  int n_err = 0;

  tensor_velocity_solve dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_tensors     (i_tensors),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_tensors_out (o_tensors_out),
    .o_vx          (o_vx),
    .o_vy          (o_vy),
    .o_degenerate  (o_degenerate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [TW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (TW - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Cramer's rule on the plain integers; SV integer division truncates toward zero.
  function automatic void model(input tensor_t t, output longint vx, output longint vy,
                                output bit dg);
    longint xx, xy, xt, yy, yt, det, nx, ny;
    xx  = t.xx;
    xy  = t.xy;
    xt  = t.xt;
    yy  = t.yy;
    yt  = t.yt;
    det = xx * yy - xy * xy;
    nx  = xy * yt - yy * xt;
    ny  = xy * xt - xx * yt;
    dg  = ((det < 0) ? -det : det) <= 0;
    if (dg) begin
      vx = 0;
      vy = 0;
    end else begin
      vx = clamp((nx * (longint'(1) <<< FRAC)) / det);
      vy = clamp((ny * (longint'(1) <<< FRAC)) / det);
    end
  endfunction

  function automatic tensor_t mk(input int xx, input int xy, input int xt,
                                 input int yy, input int yt, input int tt);
    tensor_t t;
    t.xx = xx[TW-1:0];
    t.xy = xy[TW-1:0];
    t.xt = xt[TW-1:0];
    t.yy = yy[TW-1:0];
    t.yt = yt[TW-1:0];
    t.tt = tt[TW-1:0];
    return t;
  endfunction

  function automatic int rnd(input int lim);
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  task automatic chk_word(input string tag, input tensor_t t);
    logic [TW*6-1:0] w;
    w = t;
    chk({tag, "_lo"}, longint'(o_tensors_out[TW*3-1:0]), longint'(w[TW*3-1:0]));
    chk({tag, "_hi"}, longint'(o_tensors_out[TW*6-1:TW*3]), longint'(w[TW*6-1:TW*3]));
  endtask

  // One full transaction; hold > 0 keeps out_ready low that many cycles in DONE,
  // optionally offering t2 on the input meanwhile.
  task automatic send(input string name, input tensor_t t, input int hold,
                      input bit offer, input tensor_t t2);
    longint vx_e, vy_e;
    bit     dg_e;
    int     k;
    model(t, vx_e, vy_e, dg_e);
    k = 0;
    while (!o_in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "/in_ready"}, longint'(o_in_ready), 1);
    i_in_valid  = 1'b1;
    i_tensors   = t;
    i_out_ready = (hold == 0);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!o_out_valid && k < 100);
    chk({name, "/latency"}, k, dg_e ? LAT_DEGEN : LAT_SOLVE);
    chk({name, "/vx"}, sx(o_vx), vx_e);
    chk({name, "/vy"}, sx(o_vy), vy_e);
    chk({name, "/degenerate"}, longint'(o_degenerate), longint'(dg_e));
    chk({name, "/busy"}, longint'(o_in_ready), 0);
    chk_word({name, "/tensors_out"}, t);
    if (offer) begin
      i_in_valid = 1'b1;
      i_tensors  = t2;
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk({name, "/hold_valid"}, longint'(o_out_valid), 1);
      chk({name, "/hold_vx"}, sx(o_vx), vx_e);
      chk({name, "/hold_vy"}, sx(o_vy), vy_e);
      chk({name, "/hold_deg"}, longint'(o_degenerate), longint'(dg_e));
      chk({name, "/hold_ready"}, longint'(o_in_ready), 0);
      chk_word({name, "/hold_tensors"}, t);
    end
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, "/valid_pulse"}, longint'(o_out_valid), 0);
    chk({name, "/ready_back"}, longint'(o_in_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tensor_t t, t2;
    int      bad, mode, a, hold;
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    i_tensors   = '0;
    #12;
    chk("rst/out_valid", longint'(o_out_valid), 0);
    chk("rst/vx", sx(o_vx), 0);
    chk("rst/vy", sx(o_vy), 0);
    chk("rst/degenerate", longint'(o_degenerate), 0);
    chk_word("rst/tensors_out", mk(0, 0, 0, 0, 0, 0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst/in_ready", longint'(o_in_ready), 1);
    chk("rst/out_valid_rel", longint'(o_out_valid), 0);

    t = mk(100, 0, -50, 100, 25, 0);    send("basic", t, 0, 0, t);
    t = mk(3, 0, -1, 3, 0, 0);          send("trunc_pos", t, 0, 0, t);
    t = mk(3, 0, 1, 3, 0, 0);           send("trunc_neg", t, 0, 0, t);
    t = mk(10, 10, 5, 10, 7, 3);        send("degen", t, 0, 0, t);
    t = mk(1, 0, -8000, 1, 0, 0);       send("sat_pos", t, 0, 0, t);
    t = mk(1, 0, 8000, 1, 0, 0);        send("sat_neg", t, 0, 0, t);

    t  = mk(40, 5, -30, 60, 12, 9);
    t2 = mk(200, -17, 90, 150, -44, 1);
    send("bp", t, 10, 1, t2);
    send("bp_second", t2, 0, 0, t2);

    t = mk(100, 0, -50, 100, 25, 0);
    i_in_valid  = 1'b1;
    i_tensors   = t;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    repeat (21) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("middiv/out_valid", longint'(o_out_valid), 0);
    chk("middiv/vx", sx(o_vx), 0);
    chk("middiv/vy", sx(o_vy), 0);
    chk("middiv/degenerate", longint'(o_degenerate), 0);
    chk_word("middiv/tensors_out", mk(0, 0, 0, 0, 0, 0));
    chk("middiv/in_ready", longint'(o_in_ready), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (o_out_valid) bad++;
    end
    chk("middiv/no_emit", bad, 0);
    t = mk(3, 0, -1, 3, 0, 0);
    send("after_rst", t, 0, 0, t);

    for (int n = 0; n < 60; n++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: t = mk(rnd(127), rnd(127), rnd(127), rnd(127), rnd(127), rnd(127));
        1: t = mk(rnd(8191), rnd(8191), rnd(8191), rnd(8191), rnd(8191), rnd(8191));
        2: begin
          a = rnd(600);
          t = mk(a, ($urandom_range(0, 1) == 1) ? a : -a, rnd(2000), a, rnd(2000), rnd(50));
        end
        default: t = mk(rnd(1000), rnd(300), rnd(1000), rnd(1000), rnd(1000), rnd(1000));
      endcase
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      send("rand", t, hold, 0, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
